// File: rtl/rr_mux_stage.sv
// rr_mux_stage: N-channel, W-bit registered multiplexer with valid/ready
// handshakes. A built-in arbiter (round-robin or fixed lowest-index
// priority) picks one requesting channel per cycle. The stage registers that
// channel's data and index, and holds the word while downstream backpressure
// is applied.
module rr_mux_stage #(
  parameter  int WIDTH = 25,
  parameter  int NCH   = 4,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 rr_en,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr_q;
  logic [SELW-1:0]  ptr_base;
  logic [SELW-1:0]  ptr_next;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  idx;
  logic [SELW:0]    sum;
  logic             grant_any;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  // The output register can accept a word when it is empty or is being drained.
  assign load = !out_valid || out_ready;
  assign xfer = load && grant_any && !reset;

  // Arbiter: search from ptr (round-robin) or from 0 (fixed priority).
  // The pointer and offset sums are kept one bit wider. This lets a single
  // conditional subtract give the wrap modulo NCH for any NCH, including
  // values that are not a power of two.
  always_comb begin
    ptr_base  = ptr_q;
    sum       = '0;
    idx       = '0;
    grant     = '0;
    grant_any = 1'b0;
    if ({1'b0, ptr_q} >= (SELW+1)'(NCH))
      ptr_base = ptr_q - SELW'(NCH);
    for (int unsigned k = 0; k < NCH; k++) begin
      if (rr_en) begin
        sum = {1'b0, ptr_base} + (SELW+1)'(k);
        if (sum >= (SELW+1)'(NCH))
          sum = sum - (SELW+1)'(NCH);
      end else begin
        sum = (SELW+1)'(k);
      end
      idx = sum[SELW-1:0];
      if (!grant_any && in_valid[idx]) begin
        grant     = idx;
        grant_any = 1'b1;
      end
    end
  end

  // Select the granted channel's data word.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (grant == SELW'(k))
        sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Accept strobe: one-hot on the granted channel when a transfer happens.
  always_comb begin
    in_ready = '0;
    if (xfer)
      in_ready[grant] = 1'b1;
  end

  // Next round-robin start point: the channel after the one just granted.
  always_comb begin
    if (grant == SELW'(NCH-1))
      ptr_next = '0;
    else
      ptr_next = grant + 1'b1;
  end

  // Output register: load on transfer, empty on idle drain, hold on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      if (grant_any) begin
        out_data  <= sel_data;
        out_sel   <= grant;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer: advances only on a transfer made in round-robin mode.
  always_ff @(posedge clk) begin
    if (reset)
      ptr_q <= '0;
    else if (xfer && rr_en)
      ptr_q <= ptr_next;
  end

endmodule

// File: tb/tb_rr_mux_stage.sv
// Bench for rr_mux_stage (NCH=4, WIDTH=25). A behavioural model is stepped
// and compared every cycle. Directed phases also carry hand-computed literal
// expectations.
module tb_rr_mux_stage;
  localparam int WIDTH = 25;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 rr_en;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_ready;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [WIDTH-1:0] m_data  = '0;
  int               m_sel   = 0;
  bit               m_valid = 1'b0;
  int               m_ptr   = 0;

  rr_mux_stage #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rr_en(rr_en), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // First requesting channel in search order, or -1 if none.
  function automatic int pick(input logic [NCH-1:0] v, input bit rr, input int p);
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = rr ? (p + k) % NCH : k;
      if (((v >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] chan(input int c);
    return WIDTH'(in_data >> (c * WIDTH));
  endfunction

  task automatic set_chan(input int c, input logic [WIDTH-1:0] d);
    for (int b = 0; b < WIDTH; b++) in_data[c*WIDTH + b] = d[b];
  endtask

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    int  g;
    bit  ld;
    logic [NCH-1:0] exp_ready;
    g  = pick(in_valid, rr_en, m_ptr);
    ld = !m_valid || out_ready;
    exp_ready = '0;
    if (ld && g >= 0 && !reset) exp_ready = NCH'(1 << g);
    check("in_ready",  32'(in_ready),  32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_sel",   32'(out_sel),   32'(m_sel));
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (ld) begin
      if (g >= 0) begin
        m_data  = chan(g);
        m_sel   = g;
        m_valid = 1'b1;
        if (rr_en) m_ptr = (g + 1) % NCH;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 4'b1111; rr_en = 1'b1; out_ready = 1'b1;
    in_data = '0;
    for (int c = 0; c < NCH; c++) set_chan(c, 25'h100000 + WIDTH'(c));

    // Reset held two cycles with all channels requesting
    step;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    step;
    check("rst_in_ready2", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_sel", 32'(out_sel), 32'h0);
    reset = 1'b0;
    #1;
    check("first_ready", 32'(in_ready), 32'h1);

    // Round-robin, all valid: 0,1,2,3,0 back to back
    for (int k = 0; k < 5; k++) begin
      step;
      check("rr_sel", 32'(out_sel), 32'(k % 4));
      check("rr_data", 32'(out_data), 32'h100000 + 32'(k % 4));
      check("rr_valid", 32'(out_valid), 32'h1);
    end

    // Fixed priority: ch1 wins over ch3 every cycle
    rr_en = 1'b0; in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step;
      check("fp_sel", 32'(out_sel), 32'h1);
    end
    in_valid = 4'b1000;
    step;
    check("fp_ch3", 32'(out_sel), 32'h3);
    // Pointer untouched by fixed mode: still 1 after the earlier ch0 grant
    rr_en = 1'b1; in_valid = 4'b1111;
    step;
    check("ptr_kept", 32'(out_sel), 32'h1);

    // Backpressure: load ch2 then stall three cycles
    set_chan(2, 25'h1ABCDEF);
    in_valid = 4'b0100;
    step;
    check("bp_load", 32'(out_data), 32'h1ABCDEF);
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    set_chan(0, 25'h0000055);
    for (int k = 0; k < 3; k++) begin
      step;
      check("bp_data", 32'(out_data), 32'h1ABCDEF);
      check("bp_sel", 32'(out_sel), 32'h2);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_ready", 32'(in_ready), 32'h0);
    end
    // Same-edge consume and reload; ptr was 3, ch0 wins and ptr wraps to 1
    out_ready = 1'b1;
    #1;
    check("bp_resume_ready", 32'(in_ready), 32'h1);
    step;
    check("wrap_sel", 32'(out_sel), 32'h0);
    check("wrap_data", 32'(out_data), 32'h55);
    check("wrap_valid", 32'(out_valid), 32'h1);
    in_valid = 4'b0101;
    step;
    check("sparse_sel", 32'(out_sel), 32'h2);

    // Idle drain: valid drops, data and index hold
    in_valid = 4'b0000;
    step;
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_data", 32'(out_data), 32'h1ABCDEF);
    check("idle_sel", 32'(out_sel), 32'h2);

    // Reset while a word is stalled
    in_valid = 4'b1000;
    step;
    out_ready = 1'b0; reset = 1'b1;
    step;
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_data", 32'(out_data), 32'h0);
    check("midrst_sel", 32'(out_sel), 32'h0);
    reset = 1'b0; out_ready = 1'b1;

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid  = NCH'($urandom_range(0, 15));
      for (int c = 0; c < NCH; c++) set_chan(c, WIDTH'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) rr_en = ~rr_en;
      reset = ($urandom_range(0, 99) == 0);
      step;
    end
    reset = 1'b0;
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
